// File: rtl/nco_sweep_ctrl.sv
// Stepped linear frequency sweep generator feeding the NCO phase increment.
// Optional macro NCO_SWEEP_CONTINUOUS_EN: restart the sweep instead of going idle after the final dwell.
module nco_sweep_ctrl #(
    parameter int apr = 32,
    parameter int dww = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           clken,
    input  logic           start,
    input  logic           abort,
    input  logic [apr-1:0] f_start,
    input  logic [apr-1:0] f_stop,
    input  logic [apr-1:0] f_step,
    input  logic [dww-1:0] dwell,
    output logic [apr-1:0] phi_inc_o,
    output logic           busy,
    output logic           done
);

    typedef enum logic {IDLE, DWELL} state_t;

    state_t         state, state_nxt;
    logic [apr-1:0] phi, phi_nxt;
    logic [apr-1:0] stop_q, stop_nxt;
    logic [apr-1:0] step_q, step_nxt;
    logic [dww-1:0] dwell_q, dwell_nxt;
    logic [dww-1:0] cnt, cnt_nxt;
    logic           last, last_nxt;
    logic           done_nxt;
    logic [apr:0]   sum;
    logic [apr-1:0] step_val;
`ifdef NCO_SWEEP_CONTINUOUS_EN
    logic [apr-1:0] start_q, start_nxt;
`endif

    // Next increment saturates at f_stop, including on carry out of the accumulator width.
    always_comb begin
        sum      = {1'b0, phi} + {1'b0, step_q};
        step_val = (sum[apr] || (sum[apr-1:0] >= stop_q)) ? stop_q : sum[apr-1:0];
    end

    always_comb begin
        state_nxt = state;
        phi_nxt   = phi;
        stop_nxt  = stop_q;
        step_nxt  = step_q;
        dwell_nxt = dwell_q;
        cnt_nxt   = cnt;
        last_nxt  = last;
        done_nxt  = 1'b0;
`ifdef NCO_SWEEP_CONTINUOUS_EN
        start_nxt = start_q;
`endif
        if (clken) begin
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        stop_nxt  = f_stop;
                        step_nxt  = f_step;
                        dwell_nxt = dwell;
`ifdef NCO_SWEEP_CONTINUOUS_EN
                        start_nxt = f_start;
`endif
                        phi_nxt   = f_start;
                        cnt_nxt   = dwell;
                        last_nxt  = (f_start >= f_stop);
                        state_nxt = DWELL;
                    end
                end
                DWELL: begin
                    if (abort) begin
                        state_nxt = IDLE;
                    end else if (cnt != '0) begin
                        cnt_nxt = cnt - dww'(1);
                    end else if (last) begin
                        done_nxt = 1'b1;
`ifdef NCO_SWEEP_CONTINUOUS_EN
                        phi_nxt  = start_q;
                        cnt_nxt  = dwell_q;
                        last_nxt = (start_q >= stop_q);
`else
                        state_nxt = IDLE;
`endif
                    end else begin
                        phi_nxt  = step_val;
                        cnt_nxt  = dwell_q;
                        last_nxt = (step_val == stop_q);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // done is cleared on every clk edge, so it is one clk wide even when clken is sparse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            phi     <= '0;
            stop_q  <= '0;
            step_q  <= '0;
            dwell_q <= '0;
            cnt     <= '0;
            last    <= 1'b0;
            done    <= 1'b0;
`ifdef NCO_SWEEP_CONTINUOUS_EN
            start_q <= '0;
`endif
        end else begin
            state   <= state_nxt;
            phi     <= phi_nxt;
            stop_q  <= stop_nxt;
            step_q  <= step_nxt;
            dwell_q <= dwell_nxt;
            cnt     <= cnt_nxt;
            last    <= last_nxt;
            done    <= done_nxt;
`ifdef NCO_SWEEP_CONTINUOUS_EN
            start_q <= start_nxt;
`endif
        end
    end

    assign phi_inc_o = phi;
    assign busy      = (state == DWELL);

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Directed self-checking bench for nco_sweep_ctrl with hand-computed sweep sequences.
module tb_nco_sweep_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        clken = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] f_start = '0;
    logic [31:0] f_stop = '0;
    logic [31:0] f_step = '0;
    logic [15:0] dwell = '0;
    logic [31:0] phi_inc_o;
    logic        busy;
    logic        done;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] exp_basic [12] = '{100, 100, 100, 110, 110, 110, 120, 120, 120, 130, 130, 130};
    logic [31:0] exp_clamp [4]  = '{100, 112, 124, 130};

    nco_sweep_ctrl #(.apr(32), .dww(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clken     (clken),
        .start     (start),
        .abort     (abort),
        .f_start   (f_start),
        .f_stop    (f_stop),
        .f_step    (f_step),
        .dwell     (dwell),
        .phi_inc_o (phi_inc_o),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive inputs away from the edge, then sample 1 time unit after the rising edge.
    task automatic applyStimulus(input logic s, input logic a, input logic ce);
        @(negedge clk);
        start = s;
        abort = a;
        clken = ce;
        @(posedge clk);
        #1;
    endtask

    task automatic loadSweep(input logic [31:0] fs, input logic [31:0] fe, input logic [31:0] st, input logic [15:0] dw);
        f_start = fs;
        f_stop  = fe;
        f_step  = st;
        dwell   = dw;
    endtask

    task automatic finishSweep(input string tag, input logic [31:0] final_val, input logic [31:0] start_val);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput({tag, "_done"}, {31'b0, done}, 32'd1);
`ifdef NCO_SWEEP_CONTINUOUS_EN
        checkOutput({tag, "_wrap_busy"}, {31'b0, busy}, 32'd1);
        checkOutput({tag, "_wrap_phi"}, phi_inc_o, start_val);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput({tag, "_abort_busy"}, {31'b0, busy}, 32'd0);
        checkOutput({tag, "_abort_done"}, {31'b0, done}, 32'd0);
`else
        checkOutput({tag, "_end_busy"}, {31'b0, busy}, 32'd0);
        checkOutput({tag, "_end_phi"}, phi_inc_o, final_val);
`endif
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput({tag, "_done_clr"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        #12;
        checkOutput("rst_phi", phi_inc_o, 32'd0);
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Basic sweep
        loadSweep(32'd100, 32'd130, 32'd10, 16'd2);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(i == 0, 1'b0, 1'b1);
            checkOutput($sformatf("basic_phi%0d", i), phi_inc_o, exp_basic[i]);
            checkOutput($sformatf("basic_busy%0d", i), {31'b0, busy}, 32'd1);
            checkOutput($sformatf("basic_done%0d", i), {31'b0, done}, 32'd0);
        end
        finishSweep("basic", 32'd130, 32'd100);

        // Clamp to f_stop
        loadSweep(32'd100, 32'd130, 32'd12, 16'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(i == 0, 1'b0, 1'b1);
            checkOutput($sformatf("clamp_phi%0d", i), phi_inc_o, exp_clamp[i]);
        end
        finishSweep("clamp", 32'd130, 32'd100);

        // Carry out of the accumulator width clamps as well
        loadSweep(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 16'd0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("carry_phi0", phi_inc_o, 32'hFFFF_FFF0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("carry_phi1", phi_inc_o, 32'hFFFF_FFFF);
        finishSweep("carry", 32'hFFFF_FFFF, 32'hFFFF_FFF0);

        // clken toggling 1,0,1,0
        loadSweep(32'd100, 32'd130, 32'd10, 16'd2);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(i == 0, 1'b0, 1'b1);
            checkOutput($sformatf("ce_phi%0d", i), phi_inc_o, exp_basic[i]);
            applyStimulus(1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("ce_hold%0d", i), phi_inc_o, exp_basic[i]);
            checkOutput($sformatf("ce_busy%0d", i), {31'b0, busy}, 32'd1);
        end
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("ce_done", {31'b0, done}, 32'd1);
`ifndef NCO_SWEEP_CONTINUOUS_EN
        checkOutput("ce_end_busy", {31'b0, busy}, 32'd0);
`endif
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("ce_done_clr", {31'b0, done}, 32'd0);
`ifdef NCO_SWEEP_CONTINUOUS_EN
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("ce_abort_busy", {31'b0, busy}, 32'd0);
`endif

        // Abort on the 5th tick
        loadSweep(32'd100, 32'd130, 32'd10, 16'd2);
        for (int i = 0; i < 4; i++) applyStimulus(i == 0, 1'b0, 1'b1);
        checkOutput("abort_pre_phi", phi_inc_o, 32'd110);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("abort_busy", {31'b0, busy}, 32'd0);
        checkOutput("abort_done", {31'b0, done}, 32'd0);
        checkOutput("abort_phi", phi_inc_o, 32'd110);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("abort_after_done", {31'b0, done}, 32'd0);
        checkOutput("abort_after_phi", phi_inc_o, 32'd110);

        // f_start >= f_stop, plus a start while busy with new inputs
        loadSweep(32'd200, 32'd130, 32'd10, 16'd2);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("rev_phi0", phi_inc_o, 32'd200);
        loadSweep(32'd999, 32'd5000, 32'd1, 16'd7);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("rev_phi1", phi_inc_o, 32'd200);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("rev_phi2", phi_inc_o, 32'd200);
        checkOutput("rev_busy2", {31'b0, busy}, 32'd1);
        finishSweep("rev", 32'd200, 32'd200);

        // start and abort together in IDLE
        loadSweep(32'd55, 32'd130, 32'd10, 16'd2);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("sa_busy", {31'b0, busy}, 32'd0);
        checkOutput("sa_phi", phi_inc_o, 32'd200);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("sa_busy2", {31'b0, busy}, 32'd0);

`ifdef NCO_SWEEP_CONTINUOUS_EN
        // Sawtooth repeats every 12 ticks
        loadSweep(32'd100, 32'd130, 32'd10, 16'd2);
        for (int i = 0; i < 36; i++) begin
            applyStimulus(i == 0, 1'b0, 1'b1);
            checkOutput($sformatf("cont_phi%0d", i), phi_inc_o, exp_basic[i % 12]);
            checkOutput($sformatf("cont_done%0d", i), {31'b0, done}, (i >= 12 && (i % 12) == 0) ? 32'd1 : 32'd0);
            checkOutput($sformatf("cont_busy%0d", i), {31'b0, busy}, 32'd1);
        end
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("cont_abort_busy", {31'b0, busy}, 32'd0);
        checkOutput("cont_abort_done", {31'b0, done}, 32'd0);
`endif

        // Reset in the middle of a sweep
        loadSweep(32'd100, 32'd130, 32'd10, 16'd2);
        for (int i = 0; i < 5; i++) applyStimulus(i == 0, 1'b0, 1'b1);
        checkOutput("mid_pre_busy", {31'b0, busy}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_phi", phi_inc_o, 32'd0);
        checkOutput("mid_rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("mid_rst_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            checkOutput($sformatf("post_rst_busy%0d", i), {31'b0, busy}, 32'd0);
            checkOutput($sformatf("post_rst_phi%0d", i), phi_inc_o, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
